// File: rtl/if_id_stage.sv
// Fetch-side register stage: owns the PC and the IF/ID register.
// It applies stalls and redirects, and tracks stall statistics.
module if_id_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter bit          DELAY_SLOT = 1'b1,
    parameter int unsigned STALL_MAX  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_d,
    input  logic        redirect_d,
    input  logic [31:0] redirect_pc,
    input  logic [31:0] instr_f,
    output logic [31:0] pc_f,
    output logic [31:0] instr_d,
    output logic [31:0] pc4_d,
    output logic        valid_d,
    output logic [15:0] stall_cycles,
    output logic        stall_timeout
);

    localparam int CW = $clog2(STALL_MAX + 1);

    typedef enum logic [1:0] {RUN, HOLD, HOLD_PEND} state_t;

    state_t        state, state_nx;
    logic [31:0]   pend_pc, pend_nx;
    logic [31:0]   pc_nx, pc4, target;
    logic [31:0]   instr_nx, pc4_nx;
    logic          valid_nx;
    logic          take;
    logic [CW-1:0] run_cnt;

    always_comb begin
        pc4      = pc_f + 32'd4;
        target   = redirect_d ? {redirect_pc[31:2], 2'b00} : pend_pc;
        take     = redirect_d | (state == HOLD_PEND);
        state_nx = state;
        pend_nx  = pend_pc;
        pc_nx    = pc_f;
        instr_nx = instr_d;
        pc4_nx   = pc4_d;
        valid_nx = valid_d;
        if (stall_d) begin
            if (redirect_d) begin
                pend_nx  = target;
                state_nx = HOLD_PEND;
            end else if (state == RUN) begin
                state_nx = HOLD;
            end
        end else begin
            state_nx = RUN;
            pend_nx  = '0;
            pc_nx    = take ? target : pc4;
            pc4_nx   = pc4;
            // Without a delay slot the word fetched beside a redirect is squashed
            if (take && !DELAY_SLOT) begin
                instr_nx = '0;
                valid_nx = 1'b0;
            end else begin
                instr_nx = instr_f;
                valid_nx = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RUN;
            pend_pc <= '0;
            pc_f    <= RESET_PC;
            instr_d <= '0;
            pc4_d   <= '0;
            valid_d <= 1'b0;
        end else begin
            state   <= state_nx;
            pend_pc <= pend_nx;
            pc_f    <= pc_nx;
            instr_d <= instr_nx;
            pc4_d   <= pc4_nx;
            valid_d <= valid_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles  <= '0;
            run_cnt       <= '0;
            stall_timeout <= 1'b0;
        end else begin
            if (stall_d && stall_cycles != 16'hFFFF)
                stall_cycles <= stall_cycles + 16'd1;
            if (!stall_d)
                run_cnt <= '0;
            else if (run_cnt != CW'(STALL_MAX))
                run_cnt <= run_cnt + CW'(1);
            // Set on the edge that completes the STALL_MAX-th consecutive stall
            if (stall_d && run_cnt == CW'(STALL_MAX - 1))
                stall_timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage, covering the delay-slot and squash variants.
module tb_if_id_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_d;
    logic        redirect_d;
    logic [31:0] redirect_pc;
    logic [31:0] instr_f, instr_f0;
    logic [31:0] pc_f, instr_d, pc4_d;
    logic        valid_d;
    logic [15:0] stall_cycles;
    logic        stall_timeout;
    logic [31:0] pc_f0, instr_d0, pc4_d0;
    logic        valid_d0;
    logic [15:0] stall_cycles0;
    logic        stall_timeout0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign instr_f  = 32'hAB00_0000 | pc_f;
    assign instr_f0 = 32'hAB00_0000 | pc_f0;

    if_id_stage u_dut (
        .clk(clk), .rst_n(rst_n), .stall_d(stall_d),
        .redirect_d(redirect_d), .redirect_pc(redirect_pc),
        .instr_f(instr_f), .pc_f(pc_f), .instr_d(instr_d),
        .pc4_d(pc4_d), .valid_d(valid_d),
        .stall_cycles(stall_cycles), .stall_timeout(stall_timeout)
    );

    if_id_stage #(.DELAY_SLOT(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .stall_d(stall_d),
        .redirect_d(redirect_d), .redirect_pc(redirect_pc),
        .instr_f(instr_f0), .pc_f(pc_f0), .instr_d(instr_d0),
        .pc4_d(pc4_d0), .valid_d(valid_d0),
        .stall_cycles(stall_cycles0), .stall_timeout(stall_timeout0)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_pc"}, pc_f, 32'h3000);
        check({tag, "_instr"}, instr_d, 32'h0);
        check({tag, "_pc4"}, pc4_d, 32'h0);
        check({tag, "_valid"}, {31'b0, valid_d}, 32'h0);
        check({tag, "_scyc"}, {16'b0, stall_cycles}, 32'h0);
        check({tag, "_tmo"}, {31'b0, stall_timeout}, 32'h0);
    endtask

    initial begin
        rst_n       = 1'b0;
        stall_d     = 1'b0;
        redirect_d  = 1'b0;
        redirect_pc = '0;
        step(2);
        check_reset("rst");
        rst_n = 1'b1;
        check("pc0", pc_f, 32'h3000);
        step(1);
        check("pc1", pc_f, 32'h3004);
        check("pc4_1", pc4_d, 32'h3004);
        check("instr1", instr_d, 32'hAB00_3000);
        check("valid1", {31'b0, valid_d}, 32'h1);
        step(1);
        check("pc2", pc_f, 32'h3008);

        stall_d = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("stall_pc", pc_f, 32'h3008);
            check("stall_instr", instr_d, 32'hAB00_3004);
        end
        stall_d = 1'b0;
        step(1);
        check("resume_pc", pc_f, 32'h300C);
        check("resume_instr", instr_d, 32'hAB00_3008);
        check("scyc3", {16'b0, stall_cycles}, 32'd3);
        step(1);
        check("pc_3010", pc_f, 32'h3010);

        redirect_d  = 1'b1;
        redirect_pc = 32'h3100;
        step(1);
        redirect_d = 1'b0;
        check("redir_pc", pc_f, 32'h3100);
        check("ds_instr", instr_d, 32'hAB00_3010);
        check("ds_valid", {31'b0, valid_d}, 32'h1);
        check("ds_pc4", pc4_d, 32'h3014);
        check("nods_pc", pc_f0, 32'h3100);
        check("nods_instr", instr_d0, 32'h0);
        check("nods_valid", {31'b0, valid_d0}, 32'h0);
        step(1);
        check("after_redir", pc_f, 32'h3104);
        check("after_instr", instr_d, 32'hAB00_3100);

        stall_d     = 1'b1;
        redirect_d  = 1'b1;
        redirect_pc = 32'h3200;
        step(1);
        check("pend_hold1", pc_f, 32'h3104);
        redirect_pc = 32'h3300;
        step(1);
        check("pend_hold2", pc_f, 32'h3104);
        redirect_d = 1'b0;
        step(1);
        check("pend_hold3", pc_f, 32'h3104);
        stall_d = 1'b0;
        step(1);
        check("pend_rel_pc", pc_f, 32'h3300);
        check("pend_rel_instr", instr_d, 32'hAB00_3104);
        check("pend_rel_pc4", pc4_d, 32'h3108);
        check("pend_nods_instr", instr_d0, 32'h0);
        check("pend_nods_valid", {31'b0, valid_d0}, 32'h0);
        step(1);
        check("post_pend", pc_f, 32'h3304);

        stall_d     = 1'b1;
        redirect_d  = 1'b1;
        redirect_pc = 32'h3200;
        step(1);
        stall_d     = 1'b0;
        redirect_pc = 32'h3401;
        step(1);
        redirect_d = 1'b0;
        check("fresh_wins", pc_f, 32'h3400);
        check("scyc7", {16'b0, stall_cycles}, 32'd7);

        stall_d = 1'b1;
        step(15);
        check("tmo15a", {31'b0, stall_timeout}, 32'h0);
        stall_d = 1'b0;
        step(1);
        stall_d = 1'b1;
        step(15);
        check("tmo15b", {31'b0, stall_timeout}, 32'h0);
        stall_d = 1'b0;
        step(1);
        stall_d = 1'b1;
        step(15);
        check("tmo15c", {31'b0, stall_timeout}, 32'h0);
        step(1);
        check("tmo16", {31'b0, stall_timeout}, 32'h1);
        stall_d = 1'b0;
        step(2);
        check("tmo_sticky", {31'b0, stall_timeout}, 32'h1);
        check("scyc53", {16'b0, stall_cycles}, 32'd53);

        redirect_d  = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step(1);
        redirect_d = 1'b0;
        check("wrap_pre", pc_f, 32'hFFFF_FFFC);
        step(1);
        check("wrap_pc", pc_f, 32'h0);
        check("wrap_pc4", pc4_d, 32'h0);

        stall_d     = 1'b1;
        redirect_d  = 1'b1;
        redirect_pc = 32'h3500;
        step(1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("arst");
        step(1);
        rst_n      = 1'b1;
        stall_d    = 1'b0;
        redirect_d = 1'b0;
        step(1);
        check("arst_nopend", pc_f, 32'h3004);
        check("arst_tmo", {31'b0, stall_timeout}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
